dmem_responder: RTL and testbench

Multi-cycle data-memory responder that services the load/store requests issued by the Memory stage. It accepts one request at a time over the enable/wr/addr/data_in request interface, holds the requester off with `stall` for a fixed access latency, then returns read data, or commits write data, with a one-cycle `done` pulse. It replaces the single-cycle memory model wherever the pipeline must be exercised against realistic memory latency.

---
 rtl/dmem_responder.sv | 122 ++++++++++++
 tb/tb_dmem_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
// Multi-cycle data-memory responder for the Memory stage. It takes one
// load/store at a time and holds the requester off with `stall` for LATENCY
// cycles. It then completes with a one-cycle `done` pulse. A load returns
// registered read data with that pulse. A store commits to the array at the
// completing edge.
//
// Parameters
//   ADDR_W   word-index width; array is 2^ADDR_W x 16-bit words
//   LATENCY  access latency in cycles (>= 1)
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   enable    request valid (sampled only while idle)
//   wr        1 = store, 0 = load
//   addr      byte address; addr[ADDR_W:1] is the word index, addr[0] flags
//             a misaligned access, higher bits alias
//   data_in   store data
//   data_out  load data, non-zero only in the done cycle of an aligned load
//   stall     request in progress (combinational from state only)
//   done      one-cycle completion pulse
//   err       misaligned access, pulses with done
module dmem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        stall,
  output logic        done,
  output logic        err
);

  localparam int              CNT_W    = $clog2(LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  // Latched copy of the request; inputs are not looked at again until the
  // responder returns to IDLE.
  typedef struct packed {
    logic              wr;
    logic              mis;
    logic [ADDR_W-1:0] idx;
    logic [15:0]       data;
  } req_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  req_t             req_q, req_nxt;
  logic             complete;

  logic [15:0] mem [2**ADDR_W];

  // Upper address bits alias by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[15:ADDR_W+1];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_nxt   = req_q;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt    = WAIT;
          cnt_nxt      = CNT_INIT;
          req_nxt.wr   = wr;
          req_nxt.mis  = addr[0];
          req_nxt.idx  = addr[ADDR_W:1];
          req_nxt.data = data_in;
        end
      end
      WAIT: begin
        // cnt reaches zero on the edge before completion, so the request
        // finishes LATENCY edges after acceptance.
        if (cnt == '0) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      req_q    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      data_out <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      req_q    <= req_nxt;
      done     <= complete;
      err      <= complete & req_q.mis;
      data_out <= (complete && !req_q.wr && !req_q.mis) ? mem[req_q.idx] : '0;
    end
  end

  // Array is not reset. `complete` depends on state, which the async reset
  // forces to IDLE, so an aborted store never reaches this write.
  always_ff @(posedge clk) begin
    if (complete && req_q.wr && !req_q.mis)
      mem[req_q.idx] <= req_q.data;
  end

  assign stall = (state == WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  localparam int LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        enable, wr;
  logic [15:0] addr, data_in, data_out;
  logic        stall, done, err;

  logic        enable1, wr1;
  logic [15:0] addr1, data_in1, data_out1;
  logic        stall1, done1, err1;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.ADDR_W(8), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr),
    .data_in(data_in), .data_out(data_out), .stall(stall), .done(done), .err(err)
  );

  dmem_responder #(.ADDR_W(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable1), .wr(wr1), .addr(addr1),
    .data_in(data_in1), .data_out(data_out1), .stall(stall1), .done(done1), .err(err1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: a request seen while free completes LAT
  // edges later; the responder is busy in between.
  bit          busy = 1'b0;
  int          k = 0;
  int          cmp_edge = 0;
  bit          m_wr = 1'b0, m_mis = 1'b0;
  logic [7:0]  m_idx = '0;
  logic [15:0] m_data = '0;
  logic [15:0] mem_m [int];
  bit          exp_stall = 1'b0, exp_done = 1'b0, exp_err = 1'b0, dknown = 1'b1;
  logic [15:0] exp_dout = '0;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        busy = 1'b0; exp_stall = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
        exp_dout = '0; dknown = 1'b1;
      end else begin
        k++;
        exp_done = 1'b0; exp_err = 1'b0; exp_dout = '0; dknown = 1'b1;
        if (busy) begin
          if (k == cmp_edge) begin
            busy = 1'b0;
            exp_done = 1'b1;
            if (m_mis) exp_err = 1'b1;
            else if (m_wr) mem_m[int'(m_idx)] = m_data;
            else if (mem_m.exists(int'(m_idx))) exp_dout = mem_m[int'(m_idx)];
            else dknown = 1'b0;
          end
        end else if (enable) begin
          busy = 1'b1;
          cmp_edge = k + LAT;
          m_wr = wr; m_mis = addr[0]; m_idx = addr[8:1]; m_data = data_in;
        end
        exp_stall = busy;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("done", 32'(done), 32'(exp_done));
      chk("err", 32'(err), 32'(exp_err));
      if (!exp_done || dknown) chk("data_out", 32'(data_out), 32'(exp_dout));
    end
  end

  // Issue at a negedge with the DUT idle (or in its done cycle); returns at
  // the negedge where done is seen. Scrambles inputs while waiting.
  task automatic xact(input logic w, input logic [15:0] a, input logic [15:0] d,
                      output logic [15:0] dout, output logic e, output int stalls,
                      output int cyc);
    enable = 1'b1; wr = w; addr = a; data_in = d;
    stalls = 0; cyc = 0;
    @(negedge clk); cyc++;
    for (int i = 0; i < 40; i++) begin
      if (done) break;
      if (stall) stalls++;
      enable = 1'($urandom); wr = 1'($urandom);
      addr = 16'($urandom); data_in = 16'($urandom);
      @(negedge clk); cyc++;
    end
    enable = 1'b0;
    if (!done) chk("done_timeout", 32'(done), 32'd1);
    dout = data_out; e = err;
  endtask

  logic [15:0] d, a;
  logic        e;
  int          s, c, r;

  initial begin
    rst = 1'b1; enable = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    enable1 = 1'b0; wr1 = 1'b0; addr1 = '0; data_in1 = '0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);
    chk("rst_stall1", 32'(stall1), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 1: store then load
    xact(1'b1, 16'h0010, 16'hBEEF, d, e, s, c);
    chk("t1_st_stalls", 32'(s), 32'd4);
    chk("t1_st_err", 32'(e), 32'd0);
    xact(1'b0, 16'h0010, 16'h0000, d, e, s, c);
    chk("t1_ld_data", 32'(d), 32'hBEEF);
    chk("t1_ld_err", 32'(e), 32'd0);
    chk("t1_ld_stalls", 32'(s), 32'd4);
    @(negedge clk);
    chk("t1_done_once", 32'(done), 32'd0);

    // 2: back-to-back read-after-write
    xact(1'b1, 16'h0020, 16'h1234, d, e, s, c);
    xact(1'b0, 16'h0020, 16'h0000, d, e, s, c);
    chk("t2_data", 32'(d), 32'h1234);
    chk("t2_cycles", 32'(c), 32'd5);

    // 3: misaligned store leaves the aligned word alone
    xact(1'b1, 16'h0030, 16'h7777, d, e, s, c);
    xact(1'b1, 16'h0031, 16'hAAAA, d, e, s, c);
    chk("t3_mis_err", 32'(e), 32'd1);
    chk("t3_mis_dout", 32'(d), 32'd0);
    xact(1'b0, 16'h0030, 16'h0000, d, e, s, c);
    chk("t3_data", 32'(d), 32'h7777);
    chk("t3_err", 32'(e), 32'd0);

    // 4: address wrap
    xact(1'b1, 16'h0202, 16'h5A5A, d, e, s, c);
    xact(1'b0, 16'h0002, 16'h0000, d, e, s, c);
    chk("t4_wrap", 32'(d), 32'h5A5A);

    // 5: reset in the middle of a store
    xact(1'b1, 16'h0040, 16'h1111, d, e, s, c);
    enable = 1'b1; wr = 1'b1; addr = 16'h0040; data_in = 16'hFFFF;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_busy", 32'(stall), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t5_stall_async", 32'(stall), 32'd0);
    chk("t5_done_async", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_no_done", 32'(done), 32'd0);
    end
    xact(1'b0, 16'h0040, 16'h0000, d, e, s, c);
    chk("t5_no_commit", 32'(d), 32'h1111);
    xact(1'b1, 16'h0040, 16'h0001, d, e, s, c);
    xact(1'b0, 16'h0040, 16'h0000, d, e, s, c);
    chk("t5_readback", 32'(d), 32'h0001);

    // Random traffic against the reference
    repeat (150) begin
      repeat ($urandom_range(0, 2)) begin
        enable = 1'b0; wr = 1'($urandom);
        addr = 16'($urandom); data_in = 16'($urandom);
        @(negedge clk);
      end
      a = 16'($urandom);
      a[8:1] = 8'($urandom_range(0, 15));
      a[0] = ($urandom_range(0, 3) == 0);
      xact(1'($urandom), a, 16'($urandom), d, e, s, c);
      chk("rnd_stalls", 32'(s), 32'(LAT));
    end

    // 6: LATENCY=1 with enable held high, garbage driven during WAIT
    enable1 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t6_stall", 32'(stall1), 32'(i % 2 == 1));
      chk("t6_done", 32'(done1), 32'(i >= 2 && i % 2 == 0));
      if (i >= 2 && i % 2 == 0) begin
        r = i / 2 - 1;
        chk("t6_dout", 32'(data_out1),
            (r >= 2) ? ((r % 2 == 0) ? 32'h1111 : 32'h2222) : 32'h0);
        chk("t6_err", 32'(err1), 32'd0);
      end
      if (i % 2 == 0) begin
        r = i / 2;
        wr1 = (r < 2);
        addr1 = (r % 2 == 0) ? 16'h0000 : 16'h0002;
        data_in1 = (r == 0) ? 16'h1111 : 16'h2222;
      end else begin
        wr1 = 1'b1; addr1 = 16'($urandom); data_in1 = 16'($urandom);
      end
      @(negedge clk);
    end
    enable1 = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
